// File: rtl/mano_io_unit.sv
// Mano I/O instruction responder: INPR/OUTR, FGI/FGO flags and keyboard/printer handshakes.
// Interrupt logic (IEN, R) is present only when MANO_IO_INTR_EN is defined; otherwise both read 0.
module mano_io_unit #(
    parameter int DATA_W = 8,
    parameter int IR_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [IR_W-1:0]   IN_IR,
    input  logic [2:0]        T_CNT,
    input  logic [15:0]       IN_AC,
    input  logic              CLR_R,
    input  logic [DATA_W-1:0] KBD_DATA,
    input  logic              KBD_VALID,
    output logic              KBD_READY,
    output logic [DATA_W-1:0] PRN_DATA,
    output logic              PRN_VALID,
    input  logic              PRN_READY,
    output logic [DATA_W-1:0] Q_INPR,
    output logic              LD_AC_INP,
    output logic              SKIP,
    output logic              FGI,
    output logic              FGO,
    output logic              IEN,
    output logic              Q_R
);

    logic              p;
    logic              b_inp, b_out, b_ski, b_sko, b_ion, b_iof;
    logic              kbd_xfer, prn_xfer;
    logic [DATA_W-1:0] inpr_q, inpr_d;
    logic [DATA_W-1:0] outr_q, outr_d;
    logic              fgi_q, fgi_d;
    logic              fgo_q, fgo_d;
    logic              ien_q, ien_d;
    logic              r_q, r_d;
    logic              unused_bits;

    assign p     = IN_IR[15] & (IN_IR[14:12] == 3'b111) & (T_CNT == 3'd3);
    assign b_inp = IN_IR[11];
    assign b_out = IN_IR[10];
    assign b_ski = IN_IR[9];
    assign b_sko = IN_IR[8];
    assign b_ion = IN_IR[7];
    assign b_iof = IN_IR[6];

    assign kbd_xfer = KBD_VALID & ~fgi_q;
    assign prn_xfer = PRN_READY & ~fgo_q;

    assign unused_bits = ^{IN_IR[5:0], IN_AC[15:DATA_W], CLR_R, b_ion, b_iof};

    always_comb begin
        inpr_d = inpr_q;
        outr_d = outr_q;
        fgi_d  = fgi_q;
        fgo_d  = fgo_q;
        ien_d  = ien_q;
        r_d    = r_q;

        // Keyboard set is applied after the INP clear so a same-edge transfer wins.
        if (p & b_inp) begin
            fgi_d = 1'b0;
        end
        if (kbd_xfer) begin
            inpr_d = KBD_DATA;
            fgi_d  = 1'b1;
        end

        // OUT clear is applied after printer acceptance so the new byte stays pending.
        if (prn_xfer) begin
            fgo_d = 1'b1;
        end
        if (p & b_out) begin
            outr_d = IN_AC[DATA_W-1:0];
            fgo_d  = 1'b0;
        end

`ifdef MANO_IO_INTR_EN
        if (p & b_ion) begin
            ien_d = 1'b1;
        end
        if (p & b_iof) begin
            ien_d = 1'b0;
        end
        if ((T_CNT > 3'd2) & ien_q & (fgi_q | fgo_q)) begin
            r_d = 1'b1;
        end
        if (CLR_R) begin
            r_d   = 1'b0;
            ien_d = 1'b0;
        end
`else
        ien_d = 1'b0;
        r_d   = 1'b0;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inpr_q <= '0;
            outr_q <= '0;
            fgi_q  <= 1'b0;
            fgo_q  <= 1'b1;
            ien_q  <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            inpr_q <= inpr_d;
            outr_q <= outr_d;
            fgi_q  <= fgi_d;
            fgo_q  <= fgo_d;
            ien_q  <= ien_d;
            r_q    <= r_d;
        end
    end

    assign KBD_READY = ~fgi_q;
    assign PRN_VALID = ~fgo_q;
    assign PRN_DATA  = outr_q;
    assign Q_INPR    = inpr_q;
    assign FGI       = fgi_q;
    assign FGO       = fgo_q;
    assign IEN       = ien_q;
    assign Q_R       = r_q;
    assign LD_AC_INP = p & b_inp;
    assign SKIP      = p & ((b_ski & fgi_q) | (b_sko & fgo_q));

endmodule

// File: tb/tb_mano_io_unit.sv
// Bench for mano_io_unit: directed scenarios with literal expectations, then randomized traffic vs a flag model.
// Expectations follow MANO_IO_INTR_EN the same way the design does.
module tb_mano_io_unit;

`ifdef MANO_IO_INTR_EN
    localparam bit INTR = 1'b1;
`else
    localparam bit INTR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] IN_IR = '0;
    logic [2:0]  T_CNT = '0;
    logic [15:0] IN_AC = '0;
    logic        CLR_R = 1'b0;
    logic [7:0]  KBD_DATA = '0;
    logic        KBD_VALID = 1'b0;
    logic        KBD_READY;
    logic [7:0]  PRN_DATA;
    logic        PRN_VALID;
    logic        PRN_READY = 1'b0;
    logic [7:0]  Q_INPR;
    logic        LD_AC_INP, SKIP, FGI, FGO, IEN, Q_R;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mano_io_unit #(.DATA_W(8), .IR_W(16)) dut (
        .CLK(CLK), .RST(RST), .IN_IR(IN_IR), .T_CNT(T_CNT), .IN_AC(IN_AC), .CLR_R(CLR_R),
        .KBD_DATA(KBD_DATA), .KBD_VALID(KBD_VALID), .KBD_READY(KBD_READY),
        .PRN_DATA(PRN_DATA), .PRN_VALID(PRN_VALID), .PRN_READY(PRN_READY),
        .Q_INPR(Q_INPR), .LD_AC_INP(LD_AC_INP), .SKIP(SKIP),
        .FGI(FGI), .FGO(FGO), .IEN(IEN), .Q_R(Q_R)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit io_cycle(input logic [15:0] ir, input logic [2:0] t);
        return ir[15] && (ir[14:12] == 3'b111) && (t == 3'd3);
    endfunction

    // Model: the architectural registers and the rule for each flag on a clock edge.
    logic [7:0] m_inpr, m_outr;
    bit         m_fgi, m_fgo, m_ien, m_r;
    bit         e_io, e_kbd, e_prn, e_irq;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_inpr = 8'h00; m_outr = 8'h00;
            m_fgi = 1'b0; m_fgo = 1'b1; m_ien = 1'b0; m_r = 1'b0;
        end else begin
            e_io  = io_cycle(IN_IR, T_CNT);
            e_kbd = KBD_VALID && !m_fgi;
            e_prn = PRN_READY && !m_fgo;
            e_irq = (T_CNT > 3'd2) && m_ien && (m_fgi || m_fgo);
            if (e_kbd) m_inpr = KBD_DATA;
            if (e_io && IN_IR[10]) m_outr = IN_AC[7:0];
            m_fgi = e_kbd ? 1'b1 : (e_io && IN_IR[11]) ? 1'b0 : m_fgi;
            m_fgo = (e_io && IN_IR[10]) ? 1'b0 : e_prn ? 1'b1 : m_fgo;
            if (INTR) begin
                m_r   = CLR_R ? 1'b0 : e_irq ? 1'b1 : m_r;
                m_ien = CLR_R ? 1'b0 : (e_io && IN_IR[6]) ? 1'b0 : (e_io && IN_IR[7]) ? 1'b1 : m_ien;
            end else begin
                m_r = 1'b0; m_ien = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_inpr",   Q_INPR,    m_inpr);
            chk("m_prn",    PRN_DATA,  m_outr);
            chk("m_fgi",    FGI,       m_fgi);
            chk("m_fgo",    FGO,       m_fgo);
            chk("m_kready", KBD_READY, !m_fgi);
            chk("m_pvalid", PRN_VALID, !m_fgo);
            chk("m_ien",    IEN,       m_ien);
            chk("m_r",      Q_R,       m_r);
            chk("m_ld",     LD_AC_INP, io_cycle(IN_IR, T_CNT) && IN_IR[11]);
            chk("m_skip",   SKIP,      io_cycle(IN_IR, T_CNT) &&
                                       ((IN_IR[9] && m_fgi) || (IN_IR[8] && m_fgo)));
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        IN_IR = 16'h0000; T_CNT = 3'd0; KBD_VALID = 1'b0; PRN_READY = 1'b0; CLR_R = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_fgi"},  FGI, 1'b0);
        chk({tag, "_fgo"},  FGO, 1'b1);
        chk({tag, "_ien"},  IEN, 1'b0);
        chk({tag, "_r"},    Q_R, 1'b0);
        chk({tag, "_inpr"}, Q_INPR, 8'h00);
        chk({tag, "_krdy"}, KBD_READY, 1'b1);
        chk({tag, "_pval"}, PRN_VALID, 1'b0);
    endtask

    initial begin
        #2 RST = 1'b1;
        chk_en = 1'b1;
        @(negedge CLK);
        chk_reset_state("rst0");
        cyc();
        RST = 1'b0;

        // Keyboard transfer then INP
        KBD_DATA = 8'h41; KBD_VALID = 1'b1;
        cyc();
        idle();
        @(negedge CLK);
        chk("kbd_inpr", Q_INPR, 8'h41);
        chk("kbd_fgi", FGI, 1'b1);
        chk("kbd_ready", KBD_READY, 1'b0);
        IN_IR = 16'hF800; T_CNT = 3'd3;
        @(negedge CLK);
        chk("inp_ld", LD_AC_INP, 1'b1);
        cyc();
        idle();
        @(negedge CLK);
        chk("inp_fgi", FGI, 1'b0);

        // Printer: OUT, acceptance, and OUT colliding with acceptance
        IN_AC = 16'h1234; IN_IR = 16'hF400; T_CNT = 3'd3;
        cyc();
        idle();
        @(negedge CLK);
        chk("out_data", PRN_DATA, 8'h34);
        chk("out_valid", PRN_VALID, 1'b1);
        PRN_READY = 1'b1;
        cyc();
        idle();
        @(negedge CLK);
        chk("prn_ack_fgo", FGO, 1'b1);
        IN_AC = 16'h5678; IN_IR = 16'hF400; T_CNT = 3'd3;
        cyc();
        idle();
        @(negedge CLK);
        chk("out2_data", PRN_DATA, 8'h78);
        IN_AC = 16'h9ABC; IN_IR = 16'hF400; T_CNT = 3'd3; PRN_READY = 1'b1;
        cyc();
        idle();
        @(negedge CLK);
        chk("coll_fgo", FGO, 1'b0);
        chk("coll_data", PRN_DATA, 8'hBC);
        PRN_READY = 1'b1;
        cyc();
        idle();

        // Skips
        IN_IR = 16'hF200; T_CNT = 3'd3;
        @(negedge CLK);
        chk("ski_noflag", SKIP, 1'b0);
        cyc();
        idle();
        KBD_DATA = 8'h55; KBD_VALID = 1'b1;
        cyc();
        idle();
        IN_IR = 16'hF200; T_CNT = 3'd3;
        @(negedge CLK);
        chk("ski_flag", SKIP, 1'b1);
        cyc();
        IN_IR = 16'hF100; T_CNT = 3'd3;
        @(negedge CLK);
        chk("sko_flag", SKIP, 1'b1);
        cyc();
        T_CNT = 3'd2;
        @(negedge CLK);
        chk("sko_t2", SKIP, 1'b0);
        cyc();
        idle();

        // Interrupt enable / request / acknowledge
        IN_IR = 16'hF080; T_CNT = 3'd3;
        cyc();
        idle();
        @(negedge CLK);
        chk("ion_ien", IEN, INTR);
        T_CNT = 3'd4;
        cyc();
        idle();
        @(negedge CLK);
        chk("irq_r", Q_R, INTR);
        CLR_R = 1'b1;
        cyc();
        idle();
        @(negedge CLK);
        chk("clr_r", Q_R, 1'b0);
        chk("clr_ien", IEN, 1'b0);
        IN_IR = 16'hF080; T_CNT = 3'd3;
        cyc();
        IN_IR = 16'hF0C0; T_CNT = 3'd3;
        cyc();
        idle();
        @(negedge CLK);
        chk("ionf_ien", IEN, 1'b0);
        CLR_R = 1'b1;
        cyc();
        idle();

        // Reset mid-run with flags and data registers non-zero
        RST = 1'b1;
        @(negedge CLK);
        chk_reset_state("rst1");
        chk("rst1_prn", PRN_DATA, 8'h00);
        cyc();
        RST = 1'b0;

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            if (RST) RST = 1'b0;
            else if ($urandom_range(0, 299) == 0) RST = 1'b1;
            IN_IR     = ($urandom_range(0, 1) == 1) ? {4'hF, 12'($urandom)} : 16'($urandom);
            T_CNT     = 3'($urandom);
            IN_AC     = 16'($urandom);
            KBD_DATA  = 8'($urandom);
            KBD_VALID = 1'($urandom);
            PRN_READY = 1'($urandom);
            CLR_R     = ($urandom_range(0, 15) == 0);
            cyc();
        end
        idle();
        RST = 1'b0;
        cyc();
        @(negedge CLK);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
